// File: rtl/sr_ff_monitor.sv
// Monitor for an external SR flip-flop: tracks the expected state from S/R,
// flags output mismatches and illegal S=R=1 samples, and keeps saturating event counters.
module sr_ff_monitor #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             S,
  input  logic             R,
  input  logic             Q,
  input  logic             Qbar,
  output logic             exp_q,
  output logic             exp_valid,
  output logic             mismatch,
  output logic             invalid,
  output logic             err_sticky,
  output logic [CNT_W-1:0] set_cnt,
  output logic [CNT_W-1:0] rst_cnt,
  output logic [CNT_W-1:0] inv_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    ST_UNKNOWN = 2'd0,
    ST_KNOWN0  = 2'd1,
    ST_KNOWN1  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_exp_q;
  logic             r_exp_valid;
  logic             r_mismatch;
  logic             r_invalid;
  logic             r_err_sticky;
  logic [CNT_W-1:0] r_set_cnt;
  logic [CNT_W-1:0] r_rst_cnt;
  logic [CNT_W-1:0] r_inv_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic w_set;
  logic w_rst;
  logic w_inv;
  logic w_mis;
  logic w_err;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // The check uses the state held before this edge; the update below replaces it.
  always_comb begin
    w_set = S & ~R;
    w_rst = R & ~S;
    w_inv = S & R;
    w_mis = 1'b0;
    if (r_state != ST_UNKNOWN) begin
      w_mis = (Q != r_exp_q) || (Qbar != ~r_exp_q);
    end
    w_err = w_mis | w_inv;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_UNKNOWN;
      r_exp_q      <= 1'b0;
      r_exp_valid  <= 1'b0;
      r_mismatch   <= 1'b0;
      r_invalid    <= 1'b0;
      r_err_sticky <= 1'b0;
      r_set_cnt    <= '0;
      r_rst_cnt    <= '0;
      r_inv_cnt    <= '0;
      r_err_cnt    <= '0;
    end else begin
      r_mismatch <= w_mis;
      r_invalid  <= w_inv;

      if (w_set) begin
        r_state     <= ST_KNOWN1;
        r_exp_q     <= 1'b1;
        r_exp_valid <= 1'b1;
      end else if (w_rst) begin
        r_state     <= ST_KNOWN0;
        r_exp_q     <= 1'b0;
        r_exp_valid <= 1'b1;
      end else if (w_inv) begin
        r_state     <= ST_UNKNOWN;
        r_exp_q     <= 1'b0;
        r_exp_valid <= 1'b0;
      end

      // Clear wins over any event sampled in the same cycle; pulses are unaffected.
      if (clr) begin
        r_err_sticky <= 1'b0;
        r_set_cnt    <= '0;
        r_rst_cnt    <= '0;
        r_inv_cnt    <= '0;
        r_err_cnt    <= '0;
      end else begin
        if (w_err) begin
          r_err_sticky <= 1'b1;
          r_err_cnt    <= sat_inc(r_err_cnt);
        end
        if (w_set) r_set_cnt <= sat_inc(r_set_cnt);
        if (w_rst) r_rst_cnt <= sat_inc(r_rst_cnt);
        if (w_inv) r_inv_cnt <= sat_inc(r_inv_cnt);
      end
    end
  end

  assign exp_q      = r_exp_q;
  assign exp_valid  = r_exp_valid;
  assign mismatch   = r_mismatch;
  assign invalid    = r_invalid;
  assign err_sticky = r_err_sticky;
  assign set_cnt    = r_set_cnt;
  assign rst_cnt    = r_rst_cnt;
  assign inv_cnt    = r_inv_cnt;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_sr_ff_monitor.sv
// Directed plus random bench for sr_ff_monitor at CNT_W=8 and CNT_W=2,
// checked against an abstract model of the expected flip-flop state.
module tb_sr_ff_monitor;

  logic clk, rst, clr, S, R, Q, Qbar;

  logic       a_exp_q, a_exp_valid, a_mismatch, a_invalid, a_err_sticky;
  logic [7:0] a_set_cnt, a_rst_cnt, a_inv_cnt, a_err_cnt;
  logic       b_exp_q, b_exp_valid, b_mismatch, b_invalid, b_err_sticky;
  logic [1:0] b_set_cnt, b_rst_cnt, b_inv_cnt, b_err_cnt;

  sr_ff_monitor dut8 (
    .clk(clk), .rst(rst), .clr(clr), .S(S), .R(R), .Q(Q), .Qbar(Qbar),
    .exp_q(a_exp_q), .exp_valid(a_exp_valid), .mismatch(a_mismatch),
    .invalid(a_invalid), .err_sticky(a_err_sticky),
    .set_cnt(a_set_cnt), .rst_cnt(a_rst_cnt), .inv_cnt(a_inv_cnt), .err_cnt(a_err_cnt)
  );

  sr_ff_monitor #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .clr(clr), .S(S), .R(R), .Q(Q), .Qbar(Qbar),
    .exp_q(b_exp_q), .exp_valid(b_exp_valid), .mismatch(b_mismatch),
    .invalid(b_invalid), .err_sticky(b_err_sticky),
    .set_cnt(b_set_cnt), .rst_cnt(b_rst_cnt), .inv_cnt(b_inv_cnt), .err_cnt(b_err_cnt)
  );

  int tests = 0;
  int fails = 0;

  // Model: m_state is -1 when the flip-flop value is unknown, else 0 or 1.
  // Counter index: 0 set, 1 reset, 2 invalid, 3 error.
  int m_state;
  int m_c8[4];
  int m_c2[4];
  int m_sticky, m_mis, m_inv;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = -1;
    for (int i = 0; i < 4; i++) begin
      m_c8[i] = 0;
      m_c2[i] = 0;
    end
    m_sticky = 0;
    m_mis = 0;
    m_inv = 0;
  endtask

  task automatic bump(input int idx);
    if (m_c8[idx] < 255) m_c8[idx]++;
    if (m_c2[idx] < 3) m_c2[idx]++;
  endtask

  task automatic model_edge(input logic s, input logic r, input logic q, input logic qb, input logic c);
    int want;
    m_mis = 0;
    if (m_state >= 0) begin
      want = m_state;
      m_mis = (int'(q) != want || int'(qb) != 1 - want) ? 1 : 0;
    end
    m_inv = (s && r) ? 1 : 0;
    if (c) begin
      for (int i = 0; i < 4; i++) begin
        m_c8[i] = 0;
        m_c2[i] = 0;
      end
      m_sticky = 0;
    end else begin
      if (s && !r) bump(0);
      if (r && !s) bump(1);
      if (s && r) bump(2);
      if (m_mis || m_inv) begin
        bump(3);
        m_sticky = 1;
      end
    end
    if (s && !r) m_state = 1;
    else if (r && !s) m_state = 0;
    else if (s && r) m_state = -1;
  endtask

  task automatic check_all(input string ph);
    chk({ph, ":exp_q"},      a_exp_q,      (m_state == 1));
    chk({ph, ":exp_valid"},  a_exp_valid,  (m_state >= 0));
    chk({ph, ":mismatch"},   a_mismatch,   m_mis);
    chk({ph, ":invalid"},    a_invalid,    m_inv);
    chk({ph, ":err_sticky"}, a_err_sticky, m_sticky);
    chk({ph, ":set_cnt"},    a_set_cnt,    m_c8[0]);
    chk({ph, ":rst_cnt"},    a_rst_cnt,    m_c8[1]);
    chk({ph, ":inv_cnt"},    a_inv_cnt,    m_c8[2]);
    chk({ph, ":err_cnt"},    a_err_cnt,    m_c8[3]);
    chk({ph, ":w2_exp_q"},   b_exp_q,      (m_state == 1));
    chk({ph, ":w2_mis"},     b_mismatch,   m_mis);
    chk({ph, ":w2_inv"},     b_invalid,    m_inv);
    chk({ph, ":w2_sticky"},  b_err_sticky, m_sticky);
    chk({ph, ":w2_set_cnt"}, b_set_cnt,    m_c2[0]);
    chk({ph, ":w2_rst_cnt"}, b_rst_cnt,    m_c2[1]);
    chk({ph, ":w2_inv_cnt"}, b_inv_cnt,    m_c2[2]);
    chk({ph, ":w2_err_cnt"}, b_err_cnt,    m_c2[3]);
  endtask

  // Drive inputs, take one clock edge, advance the model, compare 1 time unit later.
  task automatic step(input string ph, input logic s, input logic r,
                      input logic q, input logic qb, input logic c);
    S = s; R = r; Q = q; Qbar = qb; clr = c;
    @(posedge clk);
    model_edge(s, r, q, qb, c);
    #1;
    check_all(ph);
  endtask

  task automatic async_rst(input string ph);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all(ph);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic s, r, q, qb, c;
    rst = 1'b1; clr = 1'b0; S = 1'b0; R = 1'b0; Q = 1'b0; Qbar = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Set from UNKNOWN, then a correct hold.
    step("set1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("set1_cnt_const", a_set_cnt, 1);
    step("hold_ok", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Hold in KNOWN1 with Q dropped on the second edge.
    step("hold_a", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("hold_bad", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("mis_pulse_const", a_mismatch, 1);
    chk("mis_errcnt_const", a_err_cnt, 1);
    step("hold_c", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mis_gone_const", a_mismatch, 0);

    // Illegal S=R=1, then no comparison while UNKNOWN, then reset to KNOWN0.
    step("inv", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("inv_cnt_const", a_inv_cnt, 1);
    step("unk_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rst_known0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("known0_valid_const", a_exp_valid, 1);
    step("k0_hold", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Clear coincident with an invalid sample.
    chk("pre_clr_err_const", a_err_cnt, 2);
    step("clr_inv", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("clr_invalid_const", a_invalid, 1);
    chk("clr_errcnt_const", a_err_cnt, 0);

    // Saturation: five sets.
    step("sat0", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < 5; i++) step("sat", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("sat_w2_const", b_set_cnt, 3);
    chk("sat_w8_const", a_set_cnt, 5);

    // Asynchronous reset mid-cycle while KNOWN1.
    async_rst("midrst");
    chk("midrst_valid_const", a_exp_valid, 0);
    step("post_rst_hold", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("post_rst_set", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random traffic: mostly a well-behaved flip-flop with occasional faults.
    for (int n = 0; n < 700; n++) begin
      s = 1'($urandom_range(1));
      r = 1'($urandom_range(1));
      if (m_state < 0) q = 1'($urandom_range(1));
      else q = (m_state == 1);
      qb = ~q;
      if ($urandom_range(7) == 0) q = ~q;
      if ($urandom_range(7) == 0) qb = ~qb;
      c = ($urandom_range(15) == 0);
      step("rand", s, r, q, qb, c);
      if ($urandom_range(63) == 0) async_rst("rand_rst");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sr_ff_monitor.md
SR_FF_MONITOR -- requirements
Module: sr_ff_monitor

Interface
REQ-001 Parameter CNT_W, default 8, width of every event counter.
REQ-002 clk  input  1  single clock; all sampling and updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 clr  input  1  synchronous clear of counters and sticky error.
REQ-005 S  input  1  set input as driven to the observed SR flip-flop.
REQ-006 R  input  1  reset input as driven to the observed SR flip-flop.
REQ-007 Q  input  1  observed flip-flop output.
REQ-008 Qbar  input  1  observed flip-flop complement output.
REQ-009 exp_q  output  1  model's expected Q.
REQ-010 exp_valid  output  1  1 when exp_q is defined (state KNOWN0/KNOWN1).
REQ-011 mismatch  output  1  one-cycle pulse: Q or Qbar wrong.
REQ-012 invalid  output  1  one-cycle pulse: S=R=1 sampled.
REQ-013 err_sticky  output  1  latched OR of mismatch and invalid.
REQ-014 set_cnt, rst_cnt, inv_cnt, err_cnt  output  CNT_W each  event counters.

Function
REQ-015 FSM states: UNKNOWN, KNOWN0, KNOWN1. exp_valid=1 only in KNOWN0/KNOWN1; exp_q=1 only in KNOWN1.
REQ-016 Each edge, check first, then update; the check uses the state held before the edge (result of previous edge's S/R).
REQ-017 Check in KNOWNx: mismatch pulse next cycle if Q!=exp_q or Qbar!=~exp_q.
REQ-018 Check in UNKNOWN: no comparison; mismatch stays 0.
REQ-019 Update: S=1,R=0 -> KNOWN1, set_cnt+1; S=0,R=1 -> KNOWN0, rst_cnt+1; S=0,R=0 -> state held; S=1,R=1 -> UNKNOWN, invalid pulse, inv_cnt+1.
REQ-020 Hold in UNKNOWN stays UNKNOWN; first defined set/reset leaves UNKNOWN.
REQ-021 err_cnt+1 on every edge asserting mismatch or invalid (+1 only if both in the same cycle).
REQ-022 err_sticky set by mismatch or invalid; cleared only by rst or clr.
REQ-023 Counters saturate at 2^CNT_W-1; no wrap.
REQ-024 clr=1: counters and err_sticky to 0 at that edge; FSM and exp_q unaffected; events sampled in that same cycle are not counted, but mismatch/invalid pulses still fire.
REQ-025 Pulse latency: mismatch/invalid high exactly one cycle after the offending sample edge; consecutive events give back-to-back high.

Reset
REQ-026 rst asserted, any time: immediately state UNKNOWN, exp_q=0, exp_valid=0, mismatch=0, invalid=0, err_sticky=0, all counters 0.
REQ-027 rst deasserted: first edge after release performs normal check/update; no comparison at that edge (state UNKNOWN).
REQ-028 rst mid-sequence discards model state; the next defined set/reset re-establishes it.

Verification
REQ-029 Reset then S=1,R=0 one edge, correct DUT (Q=1,Qbar=0) -> exp_q=1, exp_valid=1, set_cnt=1, mismatch never 1, err_sticky=0.
REQ-030 KNOWN1, S=R=0 for 3 edges, Q forced 0 at 2nd -> exactly one mismatch pulse, err_cnt=1, err_sticky=1.
REQ-031 S=R=1 one edge, then S=R=0 with Q=Qbar=0 -> invalid pulse, inv_cnt=1, exp_valid=0, no mismatch; then S=0,R=1 -> KNOWN0, exp_valid=1.
REQ-032 CNT_W=2, 5 set edges -> set_cnt=3 and held.
REQ-033 err_sticky=1, err_cnt=2, clr=1 with S=R=1 same edge -> err_cnt=0, inv_cnt=0, err_sticky=0, invalid pulse still 1, state UNKNOWN.
REQ-034 rst pulsed between edges while KNOWN1 with counters nonzero -> all outputs 0 before next edge, exp_valid=0.
